// File: rtl/nes_controller_emu.sv
`default_nettype none
// ============================================================================
// Module   : nes_controller_emu
// Brief    : NES controller (4021 shift register) emulator with synchronized
//            latch/pulse inputs, frame watchdog and saturating bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module nes_controller_emu #(
    parameter int   SYNC_STAGES    = 2,
    parameter int   TIMEOUT_CYCLES = 4096,
    parameter logic FILL_LEVEL     = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons,
    output logic       data,
    output logic [3:0] bit_index,
    output logic       busy,
    output logic       frame_done
);

    localparam int                  c_WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST  = c_WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_ONE   = c_WDOG_W'(1);
    localparam logic [3:0]          c_LAST_BIT   = 4'd7;
    localparam logic [3:0]          c_FRAME_BITS = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOADED   = 2'd1,
        S_SHIFTING = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic [SYNC_STAGES-1:0] r_pulse_sync;
    logic                   r_latch_q1, r_latch_q2;
    logic                   r_pulse_q1, r_pulse_q2;

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_shreg, w_shreg_nxt;
    logic [3:0]             r_bit_index, w_bit_index_nxt;
    logic                   r_data, w_data_nxt;
    logic                   r_frame_done, w_frame_done_nxt;
    logic [c_WDOG_W-1:0]    r_wdog, w_wdog_nxt;

    logic                   w_latch_rise, w_latch_fall, w_pulse_rise;

    // The extra q1/q2 stage after the synchronizer gives the fixed
    // SYNC_STAGES+1 input-to-data latency; edges come only from q1/q2.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_latch_sync <= '0;
            r_pulse_sync <= '0;
            r_latch_q1   <= 1'b0;
            r_latch_q2   <= 1'b0;
            r_pulse_q1   <= 1'b0;
            r_pulse_q2   <= 1'b0;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latch};
            r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], pulse};
            r_latch_q1   <= r_latch_sync[SYNC_STAGES-1];
            r_latch_q2   <= r_latch_q1;
            r_pulse_q1   <= r_pulse_sync[SYNC_STAGES-1];
            r_pulse_q2   <= r_pulse_q1;
        end
    end

    assign w_latch_rise = r_latch_q1 & ~r_latch_q2;
    assign w_latch_fall = ~r_latch_q1 & r_latch_q2;
    assign w_pulse_rise = r_pulse_q1 & ~r_pulse_q2;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_bit_index  <= '0;
            r_data       <= FILL_LEVEL;
            r_frame_done <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_index  <= w_bit_index_nxt;
            r_data       <= w_data_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_wdog       <= w_wdog_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shreg_nxt      = r_shreg;
        w_bit_index_nxt  = r_bit_index;
        w_data_nxt       = r_data;
        w_frame_done_nxt = 1'b0;
        w_wdog_nxt       = r_wdog;

        case (r_state)
            S_IDLE: begin
                w_data_nxt      = FILL_LEVEL;
                w_bit_index_nxt = '0;
                w_wdog_nxt      = '0;
                if (r_latch_q1) begin
                    w_state_nxt = S_LOADED;
                    w_shreg_nxt = buttons;
                    w_data_nxt  = ~buttons[0];
                end
            end

            S_LOADED: begin
                w_bit_index_nxt = '0;
                w_wdog_nxt      = '0;
                if (r_latch_q1) begin
                    w_shreg_nxt = buttons;
                    w_data_nxt  = ~buttons[0];
                end else if (w_latch_fall) begin
                    w_state_nxt = S_SHIFTING;
                end else begin
                    // Unreachable recovery: latch low without a seen fall.
                    w_state_nxt = S_SHIFTING;
                end
            end

            S_SHIFTING, S_DONE: begin
                if (w_latch_rise) begin
                    // Abort wins over a coincident pulse edge.
                    w_state_nxt     = S_LOADED;
                    w_shreg_nxt     = buttons;
                    w_data_nxt      = ~buttons[0];
                    w_bit_index_nxt = '0;
                    w_wdog_nxt      = '0;
                end else if (w_pulse_rise) begin
                    w_wdog_nxt = '0;
                    if (r_state == S_SHIFTING) begin
                        w_shreg_nxt     = {1'b0, r_shreg[7:1]};
                        w_bit_index_nxt = r_bit_index + 4'd1;
                        if (r_bit_index == c_LAST_BIT) begin
                            w_data_nxt       = FILL_LEVEL;
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = S_DONE;
                        end else begin
                            w_data_nxt = ~r_shreg[1];
                        end
                    end else begin
                        w_data_nxt      = FILL_LEVEL;
                        w_bit_index_nxt = c_FRAME_BITS;
                    end
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_state_nxt     = S_IDLE;
                    w_data_nxt      = FILL_LEVEL;
                    w_bit_index_nxt = '0;
                    w_wdog_nxt      = '0;
                end else begin
                    w_wdog_nxt = r_wdog + c_WDOG_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign data       = r_data;
    assign bit_index  = r_bit_index;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_nes_controller_emu.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_controller_emu
// Brief    : Directed self-checking bench for nes_controller_emu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_controller_emu;

    localparam int c_TIMEOUT = 4096;

    logic       clock;
    logic       reset;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic       data;
    logic [3:0] bit_index;
    logic       busy;
    logic       frame_done;

    int checks    = 0;
    int errors    = 0;
    int fd_count  = 0;

    nes_controller_emu #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .FILL_LEVEL     (1'b0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .latch      (latch),
        .pulse      (pulse),
        .buttons    (buttons),
        .data       (data),
        .bit_index  (bit_index),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic do_tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        do_tick(6);
        pulse = 1'b0;
        do_tick(6);
    endtask

    // Expected data after the k-th shift of 8'b0000_0101 (k = 1..7).
    logic [7:0] exp_after_shift;

    initial begin
        reset   = 1'b1;
        latch   = 1'b0;
        pulse   = 1'b0;
        buttons = 8'h00;
        do_tick(3);
        check("rst_data",  int'(data), 0);
        check("rst_index", int'(bit_index), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_done",  int'(frame_done), 0);
        reset = 1'b0;
        do_tick(2);

        // Basic frame with latch latency check
        buttons = 8'b0000_0101;
        latch   = 1'b1;
        do_tick(3);
        check("latch_lat_early", int'(busy), 0);
        do_tick(1);
        check("latch_lat_busy", int'(busy), 1);
        check("loaded_data",    int'(data), 0);
        do_tick(8);
        latch = 1'b0;
        do_tick(4);
        check("shift_busy",  int'(busy), 1);
        check("shift_index", int'(bit_index), 0);
        buttons = 8'hFF;

        pulse = 1'b1;
        do_tick(3);
        check("pulse_lat_early", int'(data), 0);
        do_tick(1);
        check("pulse_lat_data",  int'(data), 1);
        check("pulse_lat_index", int'(bit_index), 1);
        do_tick(2);
        pulse = 1'b0;
        do_tick(6);

        exp_after_shift = 8'b1111_1010;
        for (int k = 2; k <= 7; k++) begin
            do_pulse();
            check($sformatf("bit%0d_data", k), int'(data), int'(exp_after_shift[k]));
            check($sformatf("bit%0d_index", k), int'(bit_index), k);
        end

        pulse = 1'b1;
        do_tick(3);
        check("p8_done_early", int'(frame_done), 0);
        check("p8_data_early", int'(data), 1);
        do_tick(1);
        check("p8_done",  int'(frame_done), 1);
        check("p8_fill",  int'(data), 0);
        check("p8_index", int'(bit_index), 8);
        do_tick(1);
        check("p8_done_once", int'(frame_done), 0);
        do_tick(1);
        pulse = 1'b0;
        do_tick(6);

        // Overrun and watchdog timeout
        do_pulse();
        do_pulse();
        check("ovr_index", int'(bit_index), 8);
        check("ovr_data",  int'(data), 0);
        check("ovr_fd",    fd_count, 1);
        do_tick(c_TIMEOUT - 16);
        check("wd_busy_hold", int'(busy), 1);
        do_tick(20);
        check("wd_busy_drop", int'(busy), 0);
        check("wd_index",     int'(bit_index), 0);

        // Abort after 3 pulses
        buttons = 8'b0000_0101;
        latch   = 1'b1;
        do_tick(12);
        latch = 1'b0;
        do_tick(6);
        do_pulse();
        do_pulse();
        do_pulse();
        check("ab_pre_index", int'(bit_index), 3);
        check("ab_pre_data",  int'(data), 1);
        buttons = 8'hFF;
        latch   = 1'b1;
        do_tick(3);
        check("ab_lat_early", int'(bit_index), 3);
        do_tick(1);
        check("ab_index", int'(bit_index), 0);
        check("ab_data",  int'(data), 0);
        do_tick(8);
        buttons = 8'h02;
        do_tick(4);
        check("reload_data", int'(data), 1);
        latch = 1'b0;
        do_tick(6);
        do_pulse();
        check("pre_prio_data",  int'(data), 0);
        check("pre_prio_index", int'(bit_index), 1);

        // Simultaneous latch and pulse rise: latch wins
        buttons = 8'h00;
        latch   = 1'b1;
        pulse   = 1'b1;
        do_tick(3);
        check("prio_early", int'(bit_index), 1);
        do_tick(1);
        check("prio_index", int'(bit_index), 0);
        check("prio_data",  int'(data), 1);
        do_tick(2);
        pulse = 1'b0;
        do_tick(6);
        check("prio_hold_index", int'(bit_index), 0);
        check("abort_no_fd",     fd_count, 1);
        latch = 1'b0;
        do_tick(6);

        // Reset mid-frame
        buttons = 8'b0000_0101;
        latch   = 1'b1;
        do_tick(12);
        latch = 1'b0;
        do_tick(6);
        for (int k = 0; k < 4; k++) do_pulse();
        check("mid_index", int'(bit_index), 4);
        check("mid_data",  int'(data), 1);
        reset = 1'b1;
        do_tick(1);
        reset = 1'b0;
        check("mid_rst_data",  int'(data), 0);
        check("mid_rst_index", int'(bit_index), 0);
        check("mid_rst_busy",  int'(busy), 0);
        check("mid_rst_done",  int'(frame_done), 0);
        for (int k = 0; k < 3; k++) do_pulse();
        check("post_rst_data",  int'(data), 0);
        check("post_rst_index", int'(bit_index), 0);
        check("post_rst_busy",  int'(busy), 0);
        check("final_fd",       fd_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
